// File: rtl/fft_cmul_pipe_if.sv
// Operand/result bus for the pipelined complex twiddle multiplier.
// Ports carried: in_valid/in_ready with operands a_re, a_im (A_W) and b_re, b_im (B_W);
// out_valid/out_ready with results p_re, p_im (OUT_W) and the per-beat sat flag.
// slave  : multiplier side (consumes operands, produces results)
// master : environment side (produces operands, consumes results)
interface fft_cmul_pipe_if #(
   parameter int unsigned A_W   = 16,
   parameter int unsigned B_W   = 10,
   parameter int unsigned OUT_W = 16
);
   logic                    in_valid;
   logic                    in_ready;
   logic signed [A_W-1:0]   a_re;
   logic signed [A_W-1:0]   a_im;
   logic signed [B_W-1:0]   b_re;
   logic signed [B_W-1:0]   b_im;
   logic                    out_valid;
   logic                    out_ready;
   logic signed [OUT_W-1:0] p_re;
   logic signed [OUT_W-1:0] p_im;
   logic                    sat;

   modport slave (
      input  in_valid, a_re, a_im, b_re, b_im, out_ready,
      output in_ready, out_valid, p_re, p_im, sat
   );

   modport master (
      output in_valid, a_re, a_im, b_re, b_im, out_ready,
      input  in_ready, out_valid, p_re, p_im, sat
   );
endinterface

// File: rtl/fft_cmul_pipe.sv
// Pipelined signed complex multiplier (a_re + j a_im)(b_re + j b_im) for FFT twiddle
// rotation, with round-half-up scaling by 2^SHIFT, saturation to OUT_W bits and a
// valid/ready handshake. One global enable (!stall) advances every stage together.
// Ports:
//   ap_clk    rising-edge clock
//   ap_rst_n  asynchronous active-low reset, clears all valid bits and outputs
//   bus       fft_cmul_pipe_if.slave: operands in, results + sat out
module fft_cmul_pipe #(
   parameter int unsigned A_W     = 16,
   parameter int unsigned B_W     = 10,
   parameter int unsigned SHIFT   = 8,
   parameter int unsigned OUT_W   = 16,
   parameter int unsigned LATENCY = 4
) (
   input  logic           ap_clk,
   input  logic           ap_rst_n,
   fft_cmul_pipe_if.slave bus
);

   localparam int unsigned PW   = A_W + B_W;    // product width
   localparam int unsigned SUMW = PW + 1;       // exact re/im sum width
   localparam int unsigned RW   = PW + 2;       // rounding headroom
   // Operands land in S1 on the accept edge; S4 plus DLY output registers gives
   // the first out_valid after edge accept+LATENCY.
   localparam int unsigned DLY  = LATENCY - 3;
   localparam int unsigned LAST = DLY - 1;

   localparam logic signed [RW-1:0] RND     = RW'(64'sd1 <<< (SHIFT - 1));
   localparam logic signed [RW-1:0] SAT_MAX = {{(RW - OUT_W + 1){1'b0}}, {(OUT_W - 1){1'b1}}};
   localparam logic signed [RW-1:0] SAT_MIN = {{(RW - OUT_W + 1){1'b1}}, {(OUT_W - 1){1'b0}}};

   // Elaboration-time parameter legality
   if (LATENCY < 4 || LATENCY > 8 || SHIFT < 1 || SHIFT >= RW || OUT_W > RW) begin : g_bad_params
      $error("fft_cmul_pipe: illegal parameters (LATENCY 4..8, SHIFT >= 1 required)");
   end

   // Round half up, floor-shift, clamp; returns {sat, value}
   function automatic logic [OUT_W:0] round_sat(input logic signed [SUMW-1:0] x);
      logic signed [RW-1:0] r;
      r = (RW'(x) + RND) >>> SHIFT;
      if (r > SAT_MAX) begin
         round_sat = {1'b1, SAT_MAX[OUT_W-1:0]};
      end else if (r < SAT_MIN) begin
         round_sat = {1'b1, SAT_MIN[OUT_W-1:0]};
      end else begin
         round_sat = {1'b0, r[OUT_W-1:0]};
      end
   endfunction

   // Stage registers
   logic                    s1_vld_q, s1_vld_d;
   logic signed [A_W-1:0]   s1_are_q, s1_are_d, s1_aim_q, s1_aim_d;
   logic signed [B_W-1:0]   s1_bre_q, s1_bre_d, s1_bim_q, s1_bim_d;
   logic                    s2_vld_q, s2_vld_d;
   logic signed [PW-1:0]    s2_rr_q, s2_rr_d, s2_ii_q, s2_ii_d;
   logic signed [PW-1:0]    s2_ri_q, s2_ri_d, s2_ir_q, s2_ir_d;
   logic                    s3_vld_q, s3_vld_d;
   logic signed [SUMW-1:0]  s3_re_q, s3_re_d, s3_im_q, s3_im_d;
   logic                    s4_vld_q, s4_vld_d;
   logic signed [OUT_W-1:0] s4_re_q, s4_re_d, s4_im_q, s4_im_d;
   logic                    s4_sat_q, s4_sat_d;
   logic                    d_vld_q [DLY];
   logic                    d_vld_d [DLY];
   logic signed [OUT_W-1:0] d_re_q  [DLY];
   logic signed [OUT_W-1:0] d_re_d  [DLY];
   logic signed [OUT_W-1:0] d_im_q  [DLY];
   logic signed [OUT_W-1:0] d_im_d  [DLY];
   logic                    d_sat_q [DLY];
   logic                    d_sat_d [DLY];

   logic             en_c;
   logic [OUT_W:0]   rs_re_c, rs_im_c;

   // Global enable: the whole pipe holds whenever the output is stalled
   assign en_c         = !(d_vld_q[LAST] && !bus.out_ready);
   assign bus.in_ready = en_c;
   assign rs_re_c      = round_sat(s3_re_q);
   assign rs_im_c      = round_sat(s3_im_q);

   // Next-state for all stages; hold by default, advance on enable
   always_comb begin
      s1_vld_d = s1_vld_q;
      s1_are_d = s1_are_q;
      s1_aim_d = s1_aim_q;
      s1_bre_d = s1_bre_q;
      s1_bim_d = s1_bim_q;
      s2_vld_d = s2_vld_q;
      s2_rr_d  = s2_rr_q;
      s2_ii_d  = s2_ii_q;
      s2_ri_d  = s2_ri_q;
      s2_ir_d  = s2_ir_q;
      s3_vld_d = s3_vld_q;
      s3_re_d  = s3_re_q;
      s3_im_d  = s3_im_q;
      s4_vld_d = s4_vld_q;
      s4_re_d  = s4_re_q;
      s4_im_d  = s4_im_q;
      s4_sat_d = s4_sat_q;
      d_vld_d  = d_vld_q;
      d_re_d   = d_re_q;
      d_im_d   = d_im_q;
      d_sat_d  = d_sat_q;
      if (en_c) begin
         s1_vld_d = bus.in_valid;
         s1_are_d = bus.a_re;
         s1_aim_d = bus.a_im;
         s1_bre_d = bus.b_re;
         s1_bim_d = bus.b_im;

         s2_vld_d = s1_vld_q;
         s2_rr_d  = PW'(s1_are_q) * PW'(s1_bre_q);
         s2_ii_d  = PW'(s1_aim_q) * PW'(s1_bim_q);
         s2_ri_d  = PW'(s1_are_q) * PW'(s1_bim_q);
         s2_ir_d  = PW'(s1_aim_q) * PW'(s1_bre_q);

         s3_vld_d = s2_vld_q;
         s3_re_d  = SUMW'(s2_rr_q) - SUMW'(s2_ii_q);
         s3_im_d  = SUMW'(s2_ri_q) + SUMW'(s2_ir_q);

         s4_vld_d = s3_vld_q;
         s4_re_d  = rs_re_c[OUT_W-1:0];
         s4_im_d  = rs_im_c[OUT_W-1:0];
         s4_sat_d = rs_re_c[OUT_W] | rs_im_c[OUT_W];

         d_vld_d[0] = s4_vld_q;
         d_re_d[0]  = s4_re_q;
         d_im_d[0]  = s4_im_q;
         d_sat_d[0] = s4_sat_q;
         for (int i = 1; i < int'(DLY); i++) begin
            d_vld_d[i] = d_vld_q[i-1];
            d_re_d[i]  = d_re_q[i-1];
            d_im_d[i]  = d_im_q[i-1];
            d_sat_d[i] = d_sat_q[i-1];
         end
      end
   end

   // State registers
   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
         s1_vld_q <= 1'b0;
         s1_are_q <= '0;
         s1_aim_q <= '0;
         s1_bre_q <= '0;
         s1_bim_q <= '0;
         s2_vld_q <= 1'b0;
         s2_rr_q  <= '0;
         s2_ii_q  <= '0;
         s2_ri_q  <= '0;
         s2_ir_q  <= '0;
         s3_vld_q <= 1'b0;
         s3_re_q  <= '0;
         s3_im_q  <= '0;
         s4_vld_q <= 1'b0;
         s4_re_q  <= '0;
         s4_im_q  <= '0;
         s4_sat_q <= 1'b0;
         for (int i = 0; i < int'(DLY); i++) begin
            d_vld_q[i] <= 1'b0;
            d_re_q[i]  <= '0;
            d_im_q[i]  <= '0;
            d_sat_q[i] <= 1'b0;
         end
      end else begin
         s1_vld_q <= s1_vld_d;
         s1_are_q <= s1_are_d;
         s1_aim_q <= s1_aim_d;
         s1_bre_q <= s1_bre_d;
         s1_bim_q <= s1_bim_d;
         s2_vld_q <= s2_vld_d;
         s2_rr_q  <= s2_rr_d;
         s2_ii_q  <= s2_ii_d;
         s2_ri_q  <= s2_ri_d;
         s2_ir_q  <= s2_ir_d;
         s3_vld_q <= s3_vld_d;
         s3_re_q  <= s3_re_d;
         s3_im_q  <= s3_im_d;
         s4_vld_q <= s4_vld_d;
         s4_re_q  <= s4_re_d;
         s4_im_q  <= s4_im_d;
         s4_sat_q <= s4_sat_d;
         d_vld_q  <= d_vld_d;
         d_re_q   <= d_re_d;
         d_im_q   <= d_im_d;
         d_sat_q  <= d_sat_d;
      end
   end

   // Final delay stage drives the result bus
   assign bus.out_valid = d_vld_q[LAST];
   assign bus.p_re      = d_re_q[LAST];
   assign bus.p_im      = d_im_q[LAST];
   assign bus.sat       = d_sat_q[LAST];

endmodule

// File: tb/tb_fft_cmul_pipe.sv
// Scoreboard bench for fft_cmul_pipe: directed twiddle cases, backpressure burst,
// mid-stream reset and a randomized stream checked against an arithmetic model.
module tb_fft_cmul_pipe;

   localparam int unsigned A_W     = 16;
   localparam int unsigned B_W     = 10;
   localparam int unsigned SHIFT   = 8;
   localparam int unsigned OUT_W   = 16;
   localparam int unsigned LATENCY = 4;

   typedef struct {
      logic signed [OUT_W-1:0] re;
      logic signed [OUT_W-1:0] im;
      logic                    sat;
      int                      acc;
      bit                      lat;
   } exp_t;

   logic ap_clk = 1'b0;
   logic ap_rst_n;
   int   cyc;
   int   checks;
   int   errors;
   bit   lat_exact;
   bit   rand_done;
   exp_t sb[$];

   fft_cmul_pipe_if #(.A_W(A_W), .B_W(B_W), .OUT_W(OUT_W)) bus ();

   fft_cmul_pipe #(
      .A_W(A_W), .B_W(B_W), .SHIFT(SHIFT), .OUT_W(OUT_W), .LATENCY(LATENCY)
   ) dut (
      .ap_clk  (ap_clk),
      .ap_rst_n(ap_rst_n),
      .bus     (bus)
   );

   always #5 ap_clk = ~ap_clk;
   always @(posedge ap_clk) cyc <= cyc + 1;

   task automatic chk(input string name, input longint act, input longint req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
      end
   endtask

   // Round half up (floor of x/2^S + 1/2), then clamp to OUT_W signed range
   function automatic longint scale(input longint x, output bit clamped);
      longint d, n, q;
      longint maxv, minv;
      d    = longint'(1) << SHIFT;
      n    = x + d / 2;
      q    = n / d;
      if ((n % d != 0) && (n < 0)) q = q - 1;
      maxv = (longint'(1) << (OUT_W - 1)) - 1;
      minv = -(longint'(1) << (OUT_W - 1));
      clamped = 1'b0;
      if (q > maxv) begin q = maxv; clamped = 1'b1; end
      if (q < minv) begin q = minv; clamped = 1'b1; end
      return q;
   endfunction

   function automatic exp_t model(input int ar, input int ai, input int br, input int bi);
      exp_t   e;
      longint re, im;
      bit     cr, ci;
      re    = longint'(ar) * longint'(br) - longint'(ai) * longint'(bi);
      im    = longint'(ar) * longint'(bi) + longint'(ai) * longint'(br);
      e.re  = OUT_W'(scale(re, cr));
      e.im  = OUT_W'(scale(im, ci));
      e.sat = cr | ci;
      e.acc = 0;
      e.lat = 1'b0;
      return e;
   endfunction

   function automatic int rnd_op(input int w);
      int r;
      case ($urandom_range(0, 7))
         0:       r = -(1 << (w - 1));
         1:       r = (1 << (w - 1)) - 1;
         default: r = int'($urandom_range(0, (1 << w) - 1)) - (1 << (w - 1));
      endcase
      return r;
   endfunction

   // Present one beat (called at posedge+1); expectation is queued on the accept edge
   task automatic send(input int ar, input int ai, input int br, input int bi,
                       input longint ere, input longint eim, input bit esat);
      exp_t e;
      int   tries;
      bit   done;
      bus.a_re     = A_W'(ar);
      bus.a_im     = A_W'(ai);
      bus.b_re     = B_W'(br);
      bus.b_im     = B_W'(bi);
      bus.in_valid = 1'b1;
      tries        = 0;
      done         = 1'b0;
      while (!done) begin
         @(negedge ap_clk);
         if (bus.in_ready) begin
            e.re  = OUT_W'(ere);
            e.im  = OUT_W'(eim);
            e.sat = esat;
            e.acc = cyc + 1;
            e.lat = lat_exact;
            sb.push_back(e);
            done  = 1'b1;
         end
         @(posedge ap_clk);
         #1;
         if (!done) begin
            tries++;
            if (tries > 500) begin
               checks++;
               errors++;
               $display("FAIL accept_timeout: in_ready low for %0d cycles, expected acceptance", tries);
               done = 1'b1;
            end
         end
      end
      bus.in_valid = 1'b0;
   endtask

   task automatic send_rand();
      int   ar, ai, br, bi;
      exp_t e;
      ar = rnd_op(A_W);
      ai = rnd_op(A_W);
      br = rnd_op(B_W);
      bi = rnd_op(B_W);
      e  = model(ar, ai, br, bi);
      send(ar, ai, br, bi, longint'(e.re), longint'(e.im), e.sat);
   endtask

   initial begin
      ap_rst_n      = 1'b0;
      bus.in_valid  = 1'b0;
      bus.a_re      = '0;
      bus.a_im      = '0;
      bus.b_re      = '0;
      bus.b_im      = '0;
      bus.out_ready = 1'b1;
      lat_exact     = 1'b1;
      rand_done     = 1'b0;

      // Monitor: pops the scoreboard on every output transfer
      fork
         begin : monitor
            exp_t                    e;
            bit                      prev_stall;
            logic signed [OUT_W-1:0] prev_re, prev_im;
            logic                    prev_sat;
            prev_stall = 1'b0;
            prev_re    = '0;
            prev_im    = '0;
            prev_sat   = 1'b0;
            forever begin
               @(negedge ap_clk);
               if (!ap_rst_n) begin
                  prev_stall = 1'b0;
               end else begin
                  chk("in_ready", longint'(bus.in_ready), longint'(!(bus.out_valid && !bus.out_ready)));
                  if (prev_stall) begin
                     chk("stall_valid", longint'(bus.out_valid), 1);
                     chk("stall_p_re", longint'(bus.p_re), longint'(prev_re));
                     chk("stall_p_im", longint'(bus.p_im), longint'(prev_im));
                     chk("stall_sat", longint'(bus.sat), longint'(prev_sat));
                  end
                  if (bus.out_valid && bus.out_ready) begin
                     if (sb.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL stale_beat: got re=%0d im=%0d, expected no output", bus.p_re, bus.p_im);
                     end else begin
                        e = sb.pop_front();
                        chk("p_re", longint'(bus.p_re), longint'(e.re));
                        chk("p_im", longint'(bus.p_im), longint'(e.im));
                        chk("sat", longint'(bus.sat), longint'(e.sat));
                        if (e.lat) chk("latency", longint'(cyc - e.acc), longint'(LATENCY));
                     end
                  end
                  prev_stall = bus.out_valid && !bus.out_ready;
                  prev_re    = bus.p_re;
                  prev_im    = bus.p_im;
                  prev_sat   = bus.sat;
               end
            end
         end
      join_none

      // Reset state
      #1;
      chk("rst_out_valid", longint'(bus.out_valid), 0);
      chk("rst_p_re", longint'(bus.p_re), 0);
      chk("rst_sat", longint'(bus.sat), 0);
      #22 ap_rst_n = 1'b1;
      @(posedge ap_clk);
      #1;
      chk("rst_in_ready", longint'(bus.in_ready), 1);

      // Directed cases, back to back, out_ready held high
      send(256, 0, 256, 0, 256, 0, 1'b0);
      send(1000, -500, 0, 256, 500, 1000, 1'b0);
      send(1, 0, 128, 0, 1, 0, 1'b0);
      send(-1, 0, 128, 0, 0, 0, 1'b0);
      send(32767, -32768, 511, 511, 32767, -2, 1'b1);
      send(-32768, -32768, 511, -512, -32768, 128, 1'b1);
      repeat (8) begin @(posedge ap_clk); #1; end

      // Backpressure: 10 beats, out_ready low for stream cycles 5..8
      lat_exact = 1'b0;
      fork
         begin
            for (int i = 0; i < 10; i++) send_rand();
         end
         begin
            for (int c = 0; c < 20; c++) begin
               bus.out_ready = !(c >= 5 && c <= 8);
               @(posedge ap_clk);
               #1;
            end
         end
      join
      bus.out_ready = 1'b1;
      repeat (8) begin @(posedge ap_clk); #1; end

      // Mid-stream reset with three beats still in the pipe behind a valid output
      lat_exact = 1'b1;
      send(100, 200, 256, 0, 100, 200, 1'b0);
      send(300, 400, 256, 0, 300, 400, 1'b0);
      send(500, 600, 256, 0, 500, 600, 1'b0);
      send(700, 800, 256, 0, 700, 800, 1'b0);
      @(posedge ap_clk);
      #2;
      chk("pre_rst_out_valid", longint'(bus.out_valid), 1);
      #1 ap_rst_n = 1'b0;
      #1;
      chk("async_rst_out_valid", longint'(bus.out_valid), 0);
      chk("async_rst_p_re", longint'(bus.p_re), 0);
      chk("async_rst_p_im", longint'(bus.p_im), 0);
      chk("async_rst_sat", longint'(bus.sat), 0);
      sb.delete();
      repeat (2) @(posedge ap_clk);
      #3 ap_rst_n = 1'b1;
      @(posedge ap_clk);
      #1;
      for (int i = 0; i < 8; i++) begin
         @(negedge ap_clk);
         chk("post_rst_idle", longint'(bus.out_valid), 0);
         @(posedge ap_clk);
         #1;
      end
      send(-300, 50, 0, -256, 50, 300, 1'b0);
      repeat (8) begin @(posedge ap_clk); #1; end

      // Randomized stream with bubbles and random backpressure
      lat_exact = 1'b0;
      fork
         begin
            for (int i = 0; i < 300; i++) begin
               if ($urandom_range(0, 3) == 0) begin
                  repeat ($urandom_range(1, 3)) begin @(posedge ap_clk); #1; end
               end
               send_rand();
            end
            rand_done = 1'b1;
         end
         begin
            while (!rand_done) begin
               bus.out_ready = ($urandom_range(0, 9) < 7);
               @(posedge ap_clk);
               #1;
            end
            bus.out_ready = 1'b1;
         end
      join

      // Drain
      bus.out_ready = 1'b1;
      for (int i = 0; i < 200 && sb.size() != 0; i++) begin
         @(posedge ap_clk);
         #1;
      end
      chk("drain_remaining", longint'(sb.size()), 0);
      repeat (4) begin @(posedge ap_clk); #1; end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
